// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - framed MSB-first serializer, optional 1,0,1 preamble (SEQ_TX_PREAMBLE_EN)
module seq_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             z,
    output logic             z_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_TX_PREAMBLE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRE = 2'd1, ST_DATA = 2'd2} state_t;
    localparam state_t FIRST = ST_PRE;
    localparam logic [CW-1:0] PRE_LAST = CW'(2);
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd2} state_t;
    localparam state_t FIRST = ST_DATA;
`endif

    // state describes the bit currently on z; cnt is its index within the phase
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, src;
    logic            z_nxt, z_valid_nxt, frame_done_nxt;
    logic            accept;

    // ready when idle or while the final data bit is out, never during reset
    assign din_ready = !reset && ((state == ST_IDLE) || ((state == ST_DATA) && (cnt == LAST)));
    assign accept    = din_valid && din_ready;

    // state, counter, shift register and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sreg       <= '0;
            z          <= IDLE_LEVEL;
            z_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sreg       <= sreg_nxt;
            z          <= z_nxt;
            z_valid    <= z_valid_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // next-state: start a frame on acceptance, chain frames with no idle gap
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = FIRST;
`ifdef SEQ_TX_PREAMBLE_EN
            ST_PRE:  if (cnt == PRE_LAST) state_nxt = ST_DATA;
`endif
            ST_DATA: if (cnt == LAST) state_nxt = accept ? FIRST : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // outputs for the coming cycle; a new frame's data comes straight from din
    always_comb begin
        src            = accept ? din : sreg;
        cnt_nxt        = '0;
        sreg_nxt       = sreg;
        z_nxt          = IDLE_LEVEL;
        z_valid_nxt    = 1'b0;
        frame_done_nxt = 1'b0;
        case (state_nxt)
`ifdef SEQ_TX_PREAMBLE_EN
            ST_PRE: begin
                cnt_nxt     = (state == ST_PRE) ? cnt + CW'(1) : '0;
                sreg_nxt    = src;
                z_nxt       = (cnt_nxt != CW'(1));
                z_valid_nxt = 1'b1;
            end
`endif
            ST_DATA: begin
                cnt_nxt        = ((state == ST_DATA) && !accept) ? cnt + CW'(1) : '0;
                z_nxt          = src[WIDTH-1];
                sreg_nxt       = src << 1;
                z_valid_nxt    = 1'b1;
                frame_done_nxt = (cnt_nxt == LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed-vector bench for seq_pattern_tx
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PREAMBLE_EN
    localparam int P = 3;
`else
    localparam int P = 0;
`endif
    localparam int FL = P + 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, z, z_valid, frame_done;
    logic [7:0] din1 = 8'h00;
    logic       din_valid1 = 1'b0;
    logic       din_ready1, z1, z_valid1, frame_done1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .z(z), .z_valid(z_valid), .frame_done(frame_done)
    );

    seq_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut_hi (
        .clk(clk), .reset(reset), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .z(z1), .z_valid(z_valid1), .frame_done(frame_done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic exp_bit(input logic [7:0] v, input int i);
        if (i < P) return (i != 1);
        return v[7-(i-P)];
    endfunction

    // called at the negedge of the first frame bit; returns one cycle after the last bit
    task automatic check_frame(input logic [7:0] v, input bit chg, input logic [7:0] cd, input logic cv);
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("z[%02h:%0d]", v, i), z, exp_bit(v, i));
            chk($sformatf("z_valid[%02h:%0d]", v, i), z_valid, 1);
            chk($sformatf("frame_done[%02h:%0d]", v, i), frame_done, (i == FL - 1));
            chk($sformatf("din_ready[%02h:%0d]", v, i), din_ready, (i == FL - 1));
            if (chg && i == 3) begin
                din       = cd;
                din_valid = cv;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_z"}, z, 0);
        chk({tag, "_z_valid"}, z_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_din_ready"}, din_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("ready_in_reset", din_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // IDLE_LEVEL=1 instance stays quiet and ready with no input
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("hi_z[%0d]", i), z1, 1);
            chk($sformatf("hi_z_valid[%0d]", i), z_valid1, 0);
            chk($sformatf("hi_din_ready[%0d]", i), din_ready1, 1);
            @(negedge clk);
        end

        // single frame A5
        din = 8'hA5; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'hA5, 1'b0, 8'h00, 1'b0);
        check_idle("after_a5");

        // back-to-back FF then 00 with valid held
        din = 8'hFF; din_valid = 1'b1;
        @(negedge clk);
        din = 8'h00;
        check_frame(8'hFF, 1'b0, 8'h00, 1'b0);
        din_valid = 1'b0;
        check_frame(8'h00, 1'b0, 8'h00, 1'b0);
        check_idle("after_b2b");

        // din changes mid-frame while busy: ignored until the boundary
        din = 8'hC3; din_valid = 1'b1;
        @(negedge clk);
        check_frame(8'hC3, 1'b1, 8'h3C, 1'b1);
        din_valid = 1'b0;
        check_frame(8'h3C, 1'b0, 8'h00, 1'b0);
        check_idle("after_busy");

        // reset in cycle 4 of an A5 frame aborts it
        din = 8'hA5; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort_z[%0d]", i), z, exp_bit(8'hA5, i));
            if (i < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_z", z, 0);
        chk("rst_z_valid", z_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_din_ready", din_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("aborted_z_valid[%0d]", i), z_valid, 0);
            chk($sformatf("aborted_frame_done[%0d]", i), frame_done, 0);
        end
        check_idle("after_abort");
        din = 8'h81; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(8'h81, 1'b0, 8'h00, 1'b0);
        check_idle("after_81");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
